port_tx_arbiter: RTL and testbench
==================================

Name: port_tx_arbiter

Overview:
- Round-robin scheduler that shares one serial Port transmitter (tr_start/din/tr_free handshake) among N_REQ byte-stream requesters.
- Each requester presents a frame as a valid/ready byte stream with a last flag. The grant is held for the whole frame, so frames never interleave on the wire.
- Sits between the frame sources of a node (forwarding queues, host injector) and its Port instance.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_LEN, 8, byte width; must match the Port's data_len.
- TIMEOUT, 255, stall limit in cycles; used only when PTA_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  N_REQ  per-requester byte valid.
- req_data  in  N_REQ*DATA_LEN  byte of requester i at [i*DATA_LEN +: DATA_LEN].
- req_last  in  N_REQ  byte is the final byte of its frame.
- req_ready  out  N_REQ  byte accepted this cycle when valid&ready.
- port_tr_free  in  1  Port transmitter idle.
- port_tr_start  out  1  one-cycle start pulse to the Port.
- port_din  out  DATA_LEN  byte to the Port; valid while port_tr_start=1.
- grant  out  N_REQ  one-hot owner of the current frame; zero when idle.
- busy  out  1  high while a frame is granted.
- frame_done  out  1  one-cycle pulse when the last byte is handed to the Port.
- abort  out  1  one-cycle pulse on timeout release; tied 0 without PTA_TIMEOUT_EN.

Behaviour:
- Reset values: grant=0, busy=0, port_tr_start=0, port_din=0, frame_done=0, abort=0, rr_ptr=0, state=IDLE. req_ready is 0 during reset.
- Port contract: the Port samples tr_start when tr_free=1 and drops tr_free on that same edge.
- No-double-start rule: the arbiter never asserts a start in the cycle directly after a start.
- States: IDLE, SEND.
- IDLE, any req_valid=1:
  - Pick the first valid index searching upward (modulo N_REQ) from rr_ptr.
  - Register the one-hot grant and set busy; enter SEND next cycle.
  - Arbitration takes 1 cycle. No byte is accepted in IDLE.
- SEND acceptance:
  - req_ready[g] = port_tr_free & ~port_tr_start. This is combinational and is the only ready bit that can be high.
  - On valid&ready at requester g: next cycle port_tr_start=1 and port_din=req_data[g]. Latency from accept to start is 1 cycle.
  - Maximum throughput is one byte per Port character time.
- Last byte (req_last[g] on accept):
  - Next cycle: frame_done=1 together with the final port_tr_start; grant=0, busy=0; rr_ptr=(g+1) mod N_REQ; state=IDLE.
- Pointer update: rr_ptr advances only on frame completion or abort, never at grant time.
- Fairness: a requester that keeps valid high waits at most N_REQ-1 frames.
- Requester deasserting valid mid-frame: the grant is held and the arbiter waits indefinitely unless PTA_TIMEOUT_EN is defined.
- Changes on req_valid/req_data of non-granted requesters are ignored.
- Single requester: back-to-back frames each go through the IDLE cycle, one idle cycle between frames.
- Reset mid-frame: all state is cleared and the pending start is dropped. A byte already started in the Port is not recalled.

Optional Feature:
- Macro: PTA_TIMEOUT_EN.
- Defined:
  - An 8+ bit stall counter counts SEND cycles where req_valid[g]=0. It clears on every accept and on grant.
  - When the counter reaches TIMEOUT: abort=1 for one cycle, grant=0, busy=0, rr_ptr=(g+1) mod N_REQ, state=IDLE.
  - No frame_done is issued on abort.
- Not defined: no counter, abort tied 0, grant held indefinitely.

Test Plan:
- Reset then idle, tr_free=1, no valid → grant=0, busy=0, no tr_start for 50 cycles.
- Req1 sends 3-byte frame 0xA1,0xA2,0xA3(last); Port model drops tr_free for 10 cycles per start → exactly 3 tr_start pulses with din A1,A2,A3 in order; frame_done coincides with A3's start; grant returns 0.
- Req0 and req2 both valid with 2-byte frames from reset → req0 served first, then req2. With all 4 requesters continuously valid, grant order is 0,1,2,3,0.
- Req3 drops valid for 20 cycles mid-frame (timeout off) → grant held, no tr_start during the gap, frame completes after valid returns.
- PTA_TIMEOUT_EN, TIMEOUT=16: req1 stalls after 1 byte → abort pulses exactly 16 cycles after the last accept; next grant goes to req2 if valid.
- Reset asserted the cycle after an accept → port_tr_start stays 0 and grant=0 the next cycle.

Source files
------------

// File: rtl/port_tx_arbiter.sv
// rtl/port_tx_arbiter.sv - round-robin frame arbiter sharing one serial Port transmitter
// Optional stall timeout release: define PTA_TIMEOUT_EN.
module port_tx_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DATA_LEN = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_LEN-1:0] req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      port_tr_free,
  output logic                      port_tr_start,
  output logic [DATA_LEN-1:0]       port_din,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      abort
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, SEND} state_t;
  state_t state;

  logic [PW-1:0]       rr_ptr;
  logic [PW-1:0]       gidx;
  logic [PW-1:0]       pick_idx;
  logic [PW-1:0]       cand;
  logic [PW-1:0]       next_ptr;
  logic                pick_found;
  logic                accept;
  logic                cur_last;
  logic [DATA_LEN-1:0] cur_data;

  // Descending scan so the candidate closest to rr_ptr is the one left standing.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr;
    cand       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = PW'((int'(rr_ptr) + k) % N_REQ);
      if (req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign next_ptr  = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
  assign cur_data  = req_data[int'(gidx)*DATA_LEN +: DATA_LEN];
  assign cur_last  = req_last[gidx];
  // Blocking on port_tr_start keeps two starts from landing on consecutive cycles.
  assign req_ready = (state == SEND && !reset && port_tr_free && !port_tr_start) ? grant : '0;
  assign accept    = |(req_valid & req_ready);

`ifdef PTA_TIMEOUT_EN
  localparam int SW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [SW-1:0] stall_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      grant         <= '0;
      busy          <= 1'b0;
      port_tr_start <= 1'b0;
      port_din      <= '0;
      frame_done    <= 1'b0;
      rr_ptr        <= '0;
      gidx          <= '0;
`ifdef PTA_TIMEOUT_EN
      abort         <= 1'b0;
      stall_cnt     <= '0;
`endif
    end else begin
      port_tr_start <= 1'b0;
      frame_done    <= 1'b0;
`ifdef PTA_TIMEOUT_EN
      abort         <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant <= N_REQ'(1) << pick_idx;
            gidx  <= pick_idx;
            busy  <= 1'b1;
            state <= SEND;
`ifdef PTA_TIMEOUT_EN
            stall_cnt <= '0;
`endif
          end
        end
        SEND: begin
          if (accept) begin
            port_tr_start <= 1'b1;
            port_din      <= cur_data;
`ifdef PTA_TIMEOUT_EN
            stall_cnt     <= '0;
`endif
            if (cur_last) begin
              frame_done <= 1'b1;
              grant      <= '0;
              busy       <= 1'b0;
              rr_ptr     <= next_ptr;
              state      <= IDLE;
            end
          end
`ifdef PTA_TIMEOUT_EN
          else if (!req_valid[gidx]) begin
            if (stall_cnt == SW'(TIMEOUT - 1)) begin
              abort  <= 1'b1;
              grant  <= '0;
              busy   <= 1'b0;
              rr_ptr <= next_ptr;
              state  <= IDLE;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
            end
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_port_tx_arbiter.sv
// tb/tb_port_tx_arbiter.sv - self-checking bench for port_tx_arbiter
// Port model holds tr_free low for 10 cycles after every start.
module tb_port_tx_arbiter;
  logic        clk;
  logic        reset;
  logic [3:0]  req_valid, req_last, req_ready, grant;
  logic [31:0] req_data;
  logic        port_tr_free, port_tr_start, busy, frame_done, abort;
  logic [7:0]  port_din;

  port_tx_arbiter #(.N_REQ(4), .DATA_LEN(8), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .port_tr_free(port_tr_free),
    .port_tr_start(port_tr_start), .port_din(port_din), .grant(grant),
    .busy(busy), .frame_done(frame_done), .abort(abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, free_cnt = 0, n_done = 0, n_abort = 0, abort_cyc = 0, acc_cyc = 0;
  logic [3:0] acc, hold, prev_grant;
  logic [8:0] src_q[4][$];
  logic [7:0] out_din[$];
  logic       out_done[$];
  logic [3:0] grant_log[$];

  typedef struct { int req; int len; logic [7:0] b0; logic [3:0] exp_grant; } vec_t;
  vec_t vt[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] glog(input int i);
    if (i < grant_log.size()) return grant_log[i];
    return 4'h0;
  endfunction

  function automatic logic [7:0] dget(input int i);
    if (i < out_din.size()) return out_din[i];
    return 8'h00;
  endfunction

  function automatic logic oget(input int i);
    if (i < out_done.size()) return out_done[i];
    return 1'b0;
  endfunction

  task automatic cycle();
    logic [8:0] head;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 4; i++)
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    if (port_tr_start) begin
      out_din.push_back(port_din);
      out_done.push_back(frame_done);
    end
    if (frame_done) begin
      n_done++;
      chk("done_with_start", {31'd0, port_tr_start}, 32'd1);
    end
    if (abort) begin
      n_abort++;
      abort_cyc = cyc;
    end
    if (grant != 4'd0 && prev_grant == 4'd0) grant_log.push_back(grant);
    prev_grant = grant;
    if (port_tr_start && port_tr_free) begin
      port_tr_free = 1'b0;
      free_cnt = 10;
    end else if (!port_tr_free) begin
      free_cnt--;
      if (free_cnt == 0) port_tr_free = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        head = src_q[i][0];
        req_valid[i] = 1'b1;
        req_data[i*8 +: 8] = head[7:0];
        req_last[i] = head[8];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i] = 1'b0;
      end
    end
    #1;
    acc = req_valid & req_ready;
    if (acc != 4'd0) acc_cyc = cyc + 1;
  endtask

  task automatic clear_logs();
    out_din.delete();
    out_done.delete();
    grant_log.delete();
    n_done = 0;
    n_abort = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) src_q[i].delete();
    hold = 4'd0;
    port_tr_free = 1'b1;
    free_cnt = 0;
    cycle();
    cycle();
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_start", {31'd0, port_tr_start}, 32'd0);
    chk("rst_din", {24'd0, port_din}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_abort", {31'd0, abort}, 32'd0);
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic push_frame(input int r, input int len, input logic [7:0] b0);
    for (int k = 0; k < len; k++) src_q[r].push_back({(k == len - 1), b0 + 8'(k)});
  endtask

  task automatic run_for_starts(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (out_din.size() < n && c < budget) begin
      cycle();
      c++;
    end
    chk({name, "_start_count"}, out_din.size(), n);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0; req_last = '0; req_data = '0;
    port_tr_free = 1'b1;
    acc = '0; hold = '0; prev_grant = '0;

    vt[0] = '{1, 3, 8'hA1, 4'b0010};
    vt[1] = '{0, 1, 8'h10, 4'b0001};
    vt[2] = '{3, 4, 8'h30, 4'b1000};
    vt[3] = '{2, 2, 8'hC0, 4'b0100};

    // Idle: nothing valid for 50 cycles.
    do_reset();
    repeat (50) cycle();
    chk("idle_starts", out_din.size(), 0);
    chk("idle_grants", grant_log.size(), 0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Single-frame vectors.
    for (int v = 0; v < 4; v++) begin
      clear_logs();
      push_frame(vt[v].req, vt[v].len, vt[v].b0);
      run_for_starts(vt[v].len, 400, $sformatf("vec%0d", v));
      repeat (3) cycle();
      for (int k = 0; k < vt[v].len; k++) begin
        chk($sformatf("vec%0d_din%0d", v, k), {24'd0, dget(k)}, {24'd0, vt[v].b0 + 8'(k)});
        chk($sformatf("vec%0d_done%0d", v, k), {31'd0, oget(k)}, (k == vt[v].len - 1) ? 32'd1 : 32'd0);
      end
      chk($sformatf("vec%0d_grant", v), {28'd0, glog(0)}, {28'd0, vt[v].exp_grant});
      chk($sformatf("vec%0d_ngrants", v), grant_log.size(), 1);
      chk($sformatf("vec%0d_ndone", v), n_done, 1);
      chk($sformatf("vec%0d_grant_end", v), {28'd0, grant}, 32'd0);
    end

    // Req0 and req2 pending from reset: 0 first, then 2.
    do_reset();
    push_frame(0, 2, 8'h01);
    push_frame(2, 2, 8'h21);
    run_for_starts(4, 400, "pair");
    repeat (3) cycle();
    chk("pair_g0", {28'd0, glog(0)}, 32'h1);
    chk("pair_g1", {28'd0, glog(1)}, 32'h4);
    chk("pair_d0", {24'd0, dget(0)}, 32'h01);
    chk("pair_d1", {24'd0, dget(1)}, 32'h02);
    chk("pair_d2", {24'd0, dget(2)}, 32'h21);
    chk("pair_d3", {24'd0, dget(3)}, 32'h22);

    // All four continuously valid: rotation 0,1,2,3,0,1,2,3.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_frame(i, 1, 8'h40 + 8'(i));
      push_frame(i, 1, 8'h50 + 8'(i));
    end
    run_for_starts(8, 800, "rr");
    repeat (3) cycle();
    for (int j = 0; j < 8; j++)
      chk($sformatf("rr_grant%0d", j), {28'd0, glog(j)}, 32'd1 << (j % 4));
    chk("rr_ndone", n_done, 8);

`ifndef PTA_TIMEOUT_EN
    // Req3 drops valid for 20 cycles mid-frame.
    do_reset();
    push_frame(3, 3, 8'h31);
    run_for_starts(1, 100, "stall_first");
    hold[3] = 1'b1;
    begin
      int bad;
      bad = 0;
      repeat (20) begin
        cycle();
        if (grant !== 4'b1000) bad++;
      end
      chk("stall_grant_held", bad, 0);
    end
    chk("stall_no_start", out_din.size(), 1);
    hold[3] = 1'b0;
    run_for_starts(3, 200, "stall_rest");
    repeat (3) cycle();
    chk("stall_d1", {24'd0, dget(1)}, 32'h32);
    chk("stall_d2", {24'd0, dget(2)}, 32'h33);
    chk("stall_ndone", n_done, 1);
    chk("stall_grant_end", {28'd0, grant}, 32'd0);
`else
    // Req1 stalls after one byte; abort 16 cycles after the accept, then req2.
    do_reset();
    push_frame(1, 3, 8'h51);
    push_frame(2, 1, 8'h61);
    begin
      int c;
      c = 0;
      while (acc[1] !== 1'b1 && c < 50) begin cycle(); c++; end
      chk("to_first_accept", {31'd0, acc[1]}, 32'd1);
      hold[1] = 1'b1;
      c = 0;
      while (n_abort == 0 && c < 100) begin cycle(); c++; end
    end
    chk("to_abort_seen", n_abort, 1);
    chk("to_abort_latency", abort_cyc - acc_cyc, 16);
    chk("to_no_done", n_done, 0);
    run_for_starts(2, 200, "to_next");
    repeat (3) cycle();
    chk("to_next_grant", {28'd0, glog(1)}, 32'h4);
    chk("to_next_din", {24'd0, dget(1)}, 32'h61);
    chk("to_abort_pulse", n_abort, 1);
`endif

    // Reset in the cycle after an accept.
    do_reset();
    push_frame(0, 2, 8'h71);
    begin
      int c;
      c = 0;
      while (acc == 4'd0 && c < 50) begin cycle(); c++; end
    end
    cycle();
    chk("mid_start", {31'd0, port_tr_start}, 32'd1);
    src_q[0].delete();
    reset = 1'b1;
    cycle();
    chk("mid_rst_start", {31'd0, port_tr_start}, 32'd0);
    chk("mid_rst_grant", {28'd0, grant}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ready", {28'd0, req_ready}, 32'd0);
    reset = 1'b0;
    repeat (5) cycle();
    chk("mid_total_starts", out_din.size(), 1);
    chk("mid_grants", grant_log.size(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
